redun_to_bin: RTL and testbench

REDUN_TO_BIN -- requirements
Module: redun_to_bin

---
 rtl/redun_to_bin.sv | 141 ++++++++++++++
 tb/tb_redun_to_bin.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/redun_to_bin.sv
// Converts a redundant-form operand (per-word coefficients with extra carry bits)
// into a fully reduced binary value: word-serial carry propagation, then bounded modular subtraction.
module redun_to_bin #(
  parameter int                               WORD_BITS       = 8,
  parameter int                               NUM_WORDS       = 4,
  parameter int                               REDUN_WORD_BITS = 1,
  parameter logic [WORD_BITS*NUM_WORDS-1:0]   MODULUS         = 128,
  parameter int                               MAX_SUB         = 4,
  localparam int                              I_WORD          = NUM_WORDS + 1,
  localparam int                              COEF_BITS       = WORD_BITS + REDUN_WORD_BITS,
  localparam int                              ACC_BITS        = I_WORD * WORD_BITS + REDUN_WORD_BITS
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic                                i_val,
  output logic                                o_rdy,
  input  logic [I_WORD-1:0][COEF_BITS-1:0]    i_dat,
  output logic                                o_val,
  input  logic                                i_rdy,
  output logic [WORD_BITS*NUM_WORDS-1:0]      o_dat,
  output logic                                o_err
);

  localparam int MOD_BITS = WORD_BITS * NUM_WORDS;
  localparam int CARRY_W  = REDUN_WORD_BITS + 1;
  // The final carry can reach 2^REDUN_WORD_BITS, so one bit above ACC_BITS keeps it lossless.
  localparam int ACC_W    = ACC_BITS + 1;
  localparam int SUM_W    = COEF_BITS + 1;
  localparam int IDX_W    = $clog2(I_WORD);
  localparam int CNT_W    = (MAX_SUB < 1) ? 1 : $clog2(MAX_SUB + 1);

  localparam logic [ACC_W-1:0] MOD_EXT  = {{(ACC_W - MOD_BITS){1'b0}}, MODULUS};
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(I_WORD - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_SUB);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CARRY = 2'd1,
    SUB   = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e                          state_q, state_d;
  logic [I_WORD-1:0][COEF_BITS-1:0] dat_q, dat_d;
  logic [ACC_W-1:0]                acc_q, acc_d;
  logic [CARRY_W-1:0]              carry_q, carry_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic                            err_q, err_d;
  logic [SUM_W-1:0]                sum;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d = state_q;
    dat_d   = dat_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    sum     = '0;

    unique case (state_q)
      IDLE: begin
        if (i_val) begin
          dat_d   = i_dat;
          acc_d   = '0;
          carry_d = '0;
          idx_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = CARRY;
        end
      end

      CARRY: begin
        for (int k = 0; k < I_WORD; k++) begin
          if (int'(idx_q) == k) begin
            sum = {1'b0, dat_q[k]} + SUM_W'(carry_q);
            acc_d[k*WORD_BITS +: WORD_BITS] = sum[WORD_BITS-1:0];
          end
        end
        carry_d = sum[SUM_W-1:WORD_BITS];
        if (idx_q == LAST_IDX) begin
          acc_d[ACC_W-1 -: CARRY_W] = carry_d;
          state_d = SUB;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      SUB: begin
        if (acc_q >= MOD_EXT) begin
          if (cnt_q < MAX_CNT) begin
            acc_d = acc_q - MOD_EXT;
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end else begin
          err_d   = 1'b0;
          state_d = DONE;
        end
      end

      DONE: begin
        if (i_rdy) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      dat_q   <= '0;
      acc_q   <= '0;
      carry_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dat_q   <= dat_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign o_rdy = (state_q == IDLE);
  assign o_val = (state_q == DONE);
  assign o_err = o_val & err_q;
  assign o_dat = o_val ? acc_q[MOD_BITS-1:0] : '0;

endmodule

// File: tb/tb_redun_to_bin.sv
// Self-checking bench for redun_to_bin: directed corner cases plus random operands
// compared against an arithmetic reference model.
module tb_redun_to_bin;

  localparam logic [31:0] MODV = 32'hFFFFFFFB;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            i_val = 1'b0;
  logic            i_rdy = 1'b0;
  logic [4:0][8:0] i_dat = '0;
  logic            o_rdy;
  logic            o_val;
  logic [31:0]     o_dat;
  logic            o_err;

  int total = 0;
  int bad   = 0;

  redun_to_bin #(
    .WORD_BITS      (8),
    .NUM_WORDS      (4),
    .REDUN_WORD_BITS(1),
    .MODULUS        (MODV),
    .MAX_SUB        (4)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_val  (i_val),
    .o_rdy  (o_rdy),
    .i_dat  (i_dat),
    .o_val  (o_val),
    .i_rdy  (i_rdy),
    .o_dat  (o_dat),
    .o_err  (o_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: weighted sum of coefficients, then up to four subtractions of the modulus.
  function automatic void model(input logic [4:0][8:0] d, output logic [31:0] e_dat,
                                output logic e_err, output int e_n);
    longint unsigned v;
    v   = 0;
    e_n = 0;
    for (int k = 0; k < 5; k++) v += longint'(d[k]) << (8 * k);
    while (v >= longint'(MODV) && e_n < 4) begin
      v -= longint'(MODV);
      e_n++;
    end
    e_err = (v >= longint'(MODV));
    e_dat = v[31:0];
  endfunction

  task automatic run_op(input logic [4:0][8:0] d, input int hold, input string tag);
    logic [31:0] e_dat;
    logic        e_err;
    int          e_n;
    int          cyc;
    model(d, e_dat, e_err, e_n);
    cyc = 0;
    while (!o_rdy && cyc < 40) begin
      @(posedge clk); #1; cyc++;
    end
    check({tag, "_rdy_before"}, 64'(o_rdy), 64'd1);
    i_dat = d;
    i_val = 1'b1;
    @(posedge clk); #1;
    i_val = 1'b0;
    cyc = 0;
    while (!o_val && cyc < 40) begin
      @(posedge clk); #1; cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(6 + e_n));
    check({tag, "_dat"}, 64'(o_dat), 64'(e_dat));
    check({tag, "_err"}, 64'(o_err), 64'(e_err));
    check({tag, "_rdy_done"}, 64'(o_rdy), 64'd0);
    for (int h = 0; h < hold; h++) begin
      i_val = (h % 2 == 0);
      @(posedge clk); #1;
      check({tag, "_hold_val"}, 64'(o_val), 64'd1);
      check({tag, "_hold_dat"}, 64'(o_dat), 64'(e_dat));
      check({tag, "_hold_err"}, 64'(o_err), 64'(e_err));
      check({tag, "_hold_rdy"}, 64'(o_rdy), 64'd0);
    end
    i_val = 1'b0;
    i_rdy = 1'b1;
    @(posedge clk); #1;
    i_rdy = 1'b0;
    check({tag, "_release_val"}, 64'(o_val), 64'd0);
    check({tag, "_release_rdy"}, 64'(o_rdy), 64'd1);
    check({tag, "_release_err"}, 64'(o_err), 64'd0);
  endtask

  initial begin
    logic [4:0][8:0] op_carry;
    logic [4:0][8:0] op_sub;
    logic [4:0][8:0] op_ovf;
    logic [4:0][8:0] op_rnd;
    int              acc_t[$];
    int              nres;
    int              cyc;

    op_carry    = '0;
    op_carry[0] = 9'h1FF;
    op_sub      = '0;
    op_sub[4]   = 9'h001;
    for (int k = 0; k < 5; k++) op_ovf[k] = 9'h1FF;

    // Reset state
    #2;
    check("reset_rdy", 64'(o_rdy), 64'd1);
    check("reset_val", 64'(o_val), 64'd0);
    check("reset_err", 64'(o_err), 64'd0);
    check("reset_dat", 64'(o_dat), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases; the first accept lands on the first edge after reset release
    run_op(op_carry, 0, "carry_only");
    check("carry_only_model", 64'(o_dat), 64'd0);
    run_op(op_sub, 0, "one_sub");
    run_op(op_ovf, 0, "overflow");
    run_op(op_carry, 3, "backpressure");

    // Reset in the middle of subtraction
    i_dat = op_sub;
    i_val = 1'b1;
    @(posedge clk); #1;
    i_val = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("midsub_not_done", 64'(o_val), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midsub_rst_rdy", 64'(o_rdy), 64'd1);
    check("midsub_rst_val", 64'(o_val), 64'd0);
    check("midsub_rst_err", 64'(o_err), 64'd0);
    check("midsub_rst_dat", 64'(o_dat), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(op_carry, 0, "after_reset");

    // Back-to-back with handshakes held high
    i_dat = op_carry;
    i_val = 1'b1;
    i_rdy = 1'b1;
    nres  = 0;
    for (int c = 0; c < 40; c++) begin
      if (o_rdy) acc_t.push_back(c);
      if (o_val) begin
        nres++;
        check("b2b_dat", 64'(o_dat), 64'h1FF);
        check("b2b_err", 64'(o_err), 64'd0);
      end
      @(posedge clk); #1;
    end
    i_val = 1'b0;
    check("b2b_accepts", 64'(acc_t.size() >= 4), 64'd1);
    check("b2b_results", 64'(nres >= 4), 64'd1);
    for (int i = 1; i < acc_t.size(); i++)
      check("b2b_spacing", 64'(acc_t[i] - acc_t[i-1]), 64'd8);
    cyc = 0;
    while (!o_rdy && cyc < 40) begin
      @(posedge clk); #1; cyc++;
    end
    i_rdy = 1'b0;
    check("b2b_drain", 64'(o_rdy), 64'd1);

    // Random operands: half with a small top word so most reduce, half fully random
    for (int r = 0; r < 12; r++) begin
      for (int k = 0; k < 4; k++) op_rnd[k] = 9'($urandom_range(0, 511));
      op_rnd[4] = (r % 2 == 0) ? 9'($urandom_range(0, 3)) : 9'($urandom_range(0, 511));
      run_op(op_rnd, $urandom_range(0, 2), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
